scene_sequencer: RTL and testbench

Frame-locked scene scheduler for the demoscene top level. Counts video frames from the VGA timing generator's `vsync` and steps through a fixed table of scenes. Drives `scene_id`, the per-scene frame count and a fade level shared by the pixel and audio generators. A pause level and a skip pulse (from the SPI side) override the automatic schedule.

---
 rtl/demoscene_pkg.sv | 27 ++
 rtl/vsync_edge_detect.sv | 34 +++
 rtl/scene_sequencer.sv | 137 +++++++++++++
 tb/tb_scene_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demoscene_pkg.sv
// demoscene_pkg: shared constants and types for the demoscene scene scheduler.
//   FADE_FRAMES : frames spent in each fade ramp (fade-in and fade-out).
//   SCENE_LEN   : frames per scene, indexed by scene_id. There are eight
//                 entries so every legal NUM_SCENES (2..8) can index it.
//                 Each entry must be >= 2*FADE_FRAMES+1 and <= 2^FRAME_W.
//   scene_state_e : scheduler state encoding.
//   scene_len() : table lookup with a fixed 3-bit index.
package demoscene_pkg;

    localparam int unsigned FADE_FRAMES = 4;
    localparam int unsigned MAX_SCENES  = 8;

    localparam int unsigned SCENE_LEN [MAX_SCENES] =
        '{240, 180, 240, 120, 240, 180, 240, 120};

    typedef enum logic [1:0] {
        WAIT_FRAME,
        FADE_IN,
        PLAY,
        FADE_OUT
    } scene_state_e;

    function automatic int unsigned scene_len(input logic [2:0] idx);
        return SCENE_LEN[idx];
    endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: registered detector for the asserting edge of vsync.
//   ACTIVE_LOW : 1 = vsync asserted low, 0 = asserted high.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   vsync      : vertical sync, synchronous to clk.
//   tick       : high for one cycle after the asserting edge has been
//                registered (asserted now, deasserted on the cycle before).
module vsync_edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;
    logic vsync_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset to the idle level so that an idle line produces no tick.
            vsync_q  <= ACTIVE_LOW;
            vsync_qq <= ACTIVE_LOW;
        end else begin
            vsync_q  <= vsync;
            vsync_qq <= vsync_q;
        end
    end

    // XOR with the polarity maps both encodings to "1 = asserted".
    assign tick = (vsync_q ^ ACTIVE_LOW) & ~(vsync_qq ^ ACTIVE_LOW);

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-locked scene scheduler.
// Counts frames from vsync, steps through the demoscene_pkg SCENE_LEN table,
// and drives the scene index, per-scene frame count and fade level.
// Optional feature macro: SCENE_FADE_EN (fade-in/fade-out ramps). Without
// it each scene plays at full level from the first frame.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset.
//   vsync        : vertical sync (polarity per VSYNC_ACTIVE_LOW).
//   pause        : level, holds frame counting while high.
//   skip         : one-cycle pulse, advance to the next scene at the next tick.
//   scene_id     : current scene index.
//   scene_frame  : frames elapsed in the current scene.
//   frame_tick   : one-cycle pulse per frame.
//   scene_change : one-cycle pulse, aligned with frame_tick, on scene advance.
//   fade_level   : 0 = black/mute, 3 = full.
import demoscene_pkg::*;

module scene_sequencer #(
    parameter int unsigned NUM_SCENES       = 4,
    parameter int unsigned FRAME_W          = 8,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          pause,
    input  logic                          skip,
    output logic [$clog2(NUM_SCENES)-1:0] scene_id,
    output logic [FRAME_W-1:0]            scene_frame,
    output logic                          frame_tick,
    output logic                          scene_change,
    output logic [1:0]                    fade_level
);

    localparam int unsigned ID_W = $clog2(NUM_SCENES);
    // One extra bit so a 2^FRAME_W scene length is representable.
    localparam int unsigned LW   = FRAME_W + 1;

    scene_state_e  state;
    logic          tick;
    logic          skip_pend;
    logic          advance;
    logic [LW-1:0] len_w;
    logic [LW-1:0] frame_w;
    logic [LW-1:0] next_w;

    vsync_edge_detect #(
        .ACTIVE_LOW (VSYNC_ACTIVE_LOW)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .tick  (tick)
    );

    always_comb begin
        len_w   = LW'(scene_len(3'(scene_id)));
        frame_w = {1'b0, scene_frame};
        next_w  = frame_w + LW'(1);
        // A skip arriving on the tick cycle itself still counts.
        advance = skip_pend | skip | (frame_w == len_w - LW'(1));
    end

`ifdef SCENE_FADE_EN
    logic [LW-1:0] fade_start;
    logic [1:0]    out_pos;
    assign fade_start = len_w - LW'(FADE_FRAMES);
    assign out_pos    = 2'(next_w - fade_start);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_FRAME;
            scene_id     <= '0;
            scene_frame  <= '0;
            frame_tick   <= 1'b0;
            scene_change <= 1'b0;
            fade_level   <= '0;
            skip_pend    <= 1'b0;
        end else begin
            frame_tick   <= tick;
            scene_change <= 1'b0;
            if (!tick) begin
                skip_pend <= skip_pend | skip;
            end else if (state == WAIT_FRAME) begin
                scene_id    <= '0;
                scene_frame <= '0;
                skip_pend   <= 1'b0;
`ifdef SCENE_FADE_EN
                state       <= FADE_IN;
                fade_level  <= '0;
`else
                state       <= PLAY;
                fade_level  <= '1;
`endif
            end else if (advance) begin
                scene_id     <= scene_id + ID_W'(1);
                scene_frame  <= '0;
                scene_change <= 1'b1;
                skip_pend    <= 1'b0;
`ifdef SCENE_FADE_EN
                state        <= FADE_IN;
                fade_level   <= '0;
`else
                state        <= PLAY;
                fade_level   <= '1;
`endif
            end else if (!pause) begin
                scene_frame <= next_w[FRAME_W-1:0];
`ifdef SCENE_FADE_EN
                case (state)
                    FADE_IN: begin
                        if (next_w == LW'(FADE_FRAMES - 1)) begin
                            state      <= PLAY;
                            fade_level <= '1;
                        end else begin
                            fade_level <= next_w[1:0];
                        end
                    end
                    PLAY: begin
                        if (next_w == fade_start) begin
                            state      <= FADE_OUT;
                            fade_level <= '1;
                        end
                    end
                    FADE_OUT: begin
                        // 3 - x over two bits is ~x.
                        fade_level <= ~out_pos;
                    end
                    default: ;
                endcase
`endif
            end
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
module tb_scene_sequencer;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       pause;
    logic       skip;
    logic [1:0] scene_id;
    logic [7:0] scene_frame;
    logic       frame_tick;
    logic       scene_change;
    logic [1:0] fade_level;

    int errors = 0;
    int checks = 0;

`ifdef SCENE_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    // Values captured on the frame_tick cycle and the cycle after it.
    logic [31:0] c_id, c_frame, c_change, c_fade;
    logic [31:0] c_tick_after, c_change_after;

    scene_sequencer #(
        .NUM_SCENES       (4),
        .FRAME_W          (8),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .pause        (pause),
        .skip         (skip),
        .scene_id     (scene_id),
        .scene_frame  (scene_frame),
        .frame_tick   (frame_tick),
        .scene_change (scene_change),
        .fade_level   (fade_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ef(input int unsigned x);
        return FADE ? 32'(x) : 32'd3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: vsync low for three cycles, optional skip on the edge cycle.
    task automatic vframe(input bit with_skip);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        skip  = with_skip;
        @(negedge clk);
        skip  = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (frame_tick === 1'b1) begin
                seen     = 1'b1;
                c_id     = 32'(scene_id);
                c_frame  = 32'(scene_frame);
                c_change = 32'(scene_change);
                c_fade   = 32'(fade_level);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        c_tick_after   = 32'(frame_tick);
        c_change_after = 32'(scene_change);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        chk("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) vframe(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b1;
        pause = 1'b0;
        skip  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_id",     32'(scene_id),     32'd0);
        chk("rst_frame",  32'(scene_frame),  32'd0);
        chk("rst_tick",   32'(frame_tick),   32'd0);
        chk("rst_change", 32'(scene_change), 32'd0);
        chk("rst_fade",   32'(fade_level),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vframe(1'b0);
        chk("t1_id", c_id, 32'd0);
        chk("t1_frame", c_frame, 32'd0);
        chk("t1_change", c_change, 32'd0);
        chk("t1_fade", c_fade, ef(0));
        vframe(1'b0);
        chk("t2_frame", c_frame, 32'd1);
        chk("t2_change", c_change, 32'd0);
        chk("t2_fade", c_fade, ef(1));
        vframe(1'b0);
        chk("t3_frame", c_frame, 32'd2);
        chk("t3_change", c_change, 32'd0);
        chk("t3_fade", c_fade, ef(2));

        run(48);
        chk("pre_pause_frame", c_frame, 32'd50);
        chk("play_fade", c_fade, 32'd3);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vframe(1'b0);
            chk("pause_frame", c_frame, 32'd50);
            chk("pause_change", c_change, 32'd0);
        end
        pause = 1'b0;
        vframe(1'b0);
        chk("resume_frame", c_frame, 32'd51);

        run(184);
        chk("s0_235", c_frame, 32'd235);
        for (int k = 0; k < 4; k++) begin
            vframe(1'b0);
            chk("fo_frame", c_frame, 32'(236 + k));
            chk("fo_fade", c_fade, ef(32'(3 - k)));
        end
        vframe(1'b0);
        chk("adv_id", c_id, 32'd1);
        chk("adv_frame", c_frame, 32'd0);
        chk("adv_change", c_change, 32'd1);
        chk("adv_fade", c_fade, ef(0));
        chk("adv_tick_width", c_tick_after, 32'd0);
        chk("adv_change_width", c_change_after, 32'd0);

        run(179);
        chk("s1_last_id", c_id, 32'd1);
        chk("s1_last_frame", c_frame, 32'd179);
        vframe(1'b0);
        chk("s2_id", c_id, 32'd2);
        chk("s2_frame", c_frame, 32'd0);
        chk("s2_change", c_change, 32'd1);

        run(100);
        chk("s2_100", c_frame, 32'd100);
        @(negedge clk); skip = 1'b1;
        @(negedge clk); skip = 1'b0;
        @(negedge clk); skip = 1'b1;
        @(negedge clk); skip = 1'b0;
        vframe(1'b0);
        chk("skip_id", c_id, 32'd3);
        chk("skip_frame", c_frame, 32'd0);
        chk("skip_change", c_change, 32'd1);
        chk("skip_fade", c_fade, ef(0));
        vframe(1'b0);
        chk("skip_once_id", c_id, 32'd3);
        chk("skip_once_frame", c_frame, 32'd1);
        chk("skip_once_change", c_change, 32'd0);

        run(118);
        chk("s3_last", c_frame, 32'd119);
        vframe(1'b0);
        chk("wrap_id", c_id, 32'd0);
        chk("wrap_frame", c_frame, 32'd0);
        chk("wrap_change", c_change, 32'd1);

        run(237);
        chk("pre_rst_frame", c_frame, 32'd237);
        chk("pre_rst_fade", c_fade, ef(2));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_id",     32'(scene_id),     32'd0);
        chk("mid_rst_frame",  32'(scene_frame),  32'd0);
        chk("mid_rst_tick",   32'(frame_tick),   32'd0);
        chk("mid_rst_change", 32'(scene_change), 32'd0);
        chk("mid_rst_fade",   32'(fade_level),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vframe(1'b0);
        chk("restart_id", c_id, 32'd0);
        chk("restart_frame", c_frame, 32'd0);
        chk("restart_change", c_change, 32'd0);
        chk("restart_fade", c_fade, ef(0));

        vframe(1'b1);
        chk("edge_skip_id", c_id, 32'd1);
        chk("edge_skip_frame", c_frame, 32'd0);
        chk("edge_skip_change", c_change, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
